cipher_frame_sequencer: RTL
===========================

// Module: cipher_frame_sequencer
// PURPOSE
//  Sequences the 64-bit block-cipher datapath (encrypt/decrypt cores) between the UART receiver and transmitter.
//  - Assembles 8 received bytes, MSB first, into a block.
//  - Loads the block into the encrypt or decrypt core input register and waits a settle time.
//  - Captures the selected core output and serializes it, MSB first, to the UART transmitter with a START/BUSY handshake.
//  - Owns inter-byte timeout, overrun detection and frame status for the top level.
// PARAMETERS
//  SETTLE_CYCLES   7       cycles between core-input update and output capture (1..255)
//  TIMEOUT_CYCLES  100000  idle cycles that discard a partial RX frame; 0 disables the timeout
// PORTS
//  CLK         in   1   system clock; all logic on posedge
//  RST_N       in   1   asynchronous active-low reset
//  RX_DATA     in   8   received byte, valid when RX_VALID=1
//  RX_VALID    in   1   one-cycle strobe per received byte
//  MODE        in   1   1 = encrypt, 0 = decrypt; sampled only on the 8th RX byte
//  ENC_IN      out  64  registered encrypt-core input
//  DEC_IN      out  64  registered decrypt-core input
//  ENC_OUT     in   64  encrypt-core output (combinational core)
//  DEC_OUT     in   64  decrypt-core output (combinational core)
//  TX_DATA     out  8   byte to transmit
//  TX_START    out  1   one-cycle transmit request
//  TX_BUSY     in   1   transmitter busy
//  BUSY        out  1   high in every state except RECV
//  BLOCK_DONE  out  1   one-cycle pulse after the 8th TX byte completes
//  TIMEOUT     out  1   one-cycle pulse when a partial frame is discarded
//  OVERRUN     out  1   sticky: RX byte arrived while BUSY; cleared only by reset
//  FRAME_CNT   out  16  completed blocks, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset values: all outputs 0, internal buffers 0, state=RECV, byte index=0, mode latch=1.
//  Reset mid-operation aborts immediately: no further TX_START, and the partial frame is lost.
//  RECV
//   - RX_VALID stores RX_DATA at byte[idx] (idx 0 = bits 63:56), then idx++.
//   - On idx=7 with RX_VALID: latch MODE; write the full block to ENC_IN if MODE=1, else DEC_IN.
//     The other input register holds. Then idx<=0 and go to SETTLE.
//   - Timeout counter clears on every RX_VALID and runs only while idx!=0.
//     When it reaches TIMEOUT_CYCLES: idx<=0, TIMEOUT pulses, buffers untouched.
//   - RX_VALID in the same cycle as the expiry: the byte is taken as byte 0 of a new frame and TIMEOUT still pulses.
//  SETTLE
//   - Counts SETTLE_CYCLES cycles starting the cycle after the core-input write.
//   - On the last count, captures ENC_OUT or DEC_OUT (per latched mode) into the out buffer; go to SEND.
//  SEND
//   - If TX_BUSY=0: TX_DATA<=out[63-8*idx -: 8], TX_START<=1 for exactly one cycle; go to WAIT_ACK.
//   - Otherwise stay in SEND.
//  WAIT_ACK
//   - Wait for TX_BUSY=1, then go to WAIT_DONE. TX_DATA is held stable until WAIT_DONE exits.
//  WAIT_DONE
//   - Wait for TX_BUSY=0.
//   - If idx=7: idx<=0, BLOCK_DONE pulses, FRAME_CNT++, go to RECV.
//   - Else: idx++, go to SEND.
//  Latency: 8th RX_VALID -> first TX_START = SETTLE_CYCLES+2 cycles when TX_BUSY=0.
//  RX_VALID outside RECV: byte dropped, OVERRUN<=1; state and buffers unaffected.
//  MODE changes outside the 8th-byte cycle have no effect on the current block.
// TESTING
//  - Reset, MODE=1, send bytes 00..07, ENC_OUT model=~IN -> ENC_IN=0x0001020304050607, DEC_IN=0;
//    TX bytes FF,FE,...,F8; BLOCK_DONE once; FRAME_CNT=1.
//  - MODE=0, send 8 bytes of 0xAA, DEC_OUT model=IN^0x55.. -> DEC_IN=0xAAAA..AA, ENC_IN unchanged;
//    TX bytes all 0xFF; first TX_START exactly SETTLE_CYCLES+2 cycles after the 8th RX_VALID.
//  - TIMEOUT_CYCLES=50: send 3 bytes, idle 50 cycles -> TIMEOUT pulse, no TX;
//    next 8 bytes form a clean block.
//  - Hold TX_BUSY high 1000 cycles during SEND -> no TX_START; TX_BUSY ACK delays of 0..20 cycles
//    -> exactly one TX_START per byte, TX_DATA stable throughout.
//  - RX_VALID during WAIT_DONE -> OVERRUN=1 and stays set; TX sequence and FRAME_CNT unaffected.
//  - Assert RST_N low after the 4th TX byte -> outputs 0 on the same edge, no further TX_START;
//    after release, a new 8-byte frame processes normally.

Source files
------------

// File: rtl/cipher_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cipher_frame_sequencer
// Description : Moves 64-bit blocks from the UART receiver through the encrypt
//               or decrypt core and serialises the result to the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_frame_sequencer #(
    parameter int SETTLE_CYCLES  = 7,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        mode,
    output logic [63:0] enc_in,
    output logic [63:0] dec_in,
    input  logic [63:0] enc_out,
    input  logic [63:0] dec_out,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        block_done,
    output logic        timeout,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        RECV      = 3'd0,
        SETTLE    = 3'd1,
        SEND      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [63:0]   rx_buf;
    logic [63:0]   out_buf;
    logic          mode_q;
    logic [7:0]    settle_cnt;
    logic [TW-1:0] to_cnt;
    logic          expire;

    // A partial frame expires once the idle counter has reached the limit.
    assign expire = (TIMEOUT_CYCLES != 0) && (state == RECV) && (idx != 3'd0)
                    && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RECV;
            idx        <= 3'd0;
            rx_buf     <= 64'd0;
            out_buf    <= 64'd0;
            mode_q     <= 1'b1;
            settle_cnt <= 8'd0;
            to_cnt     <= '0;
            enc_in     <= 64'd0;
            dec_in     <= 64'd0;
            tx_data    <= 8'd0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            block_done <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            tx_start   <= 1'b0;
            block_done <= 1'b0;
            timeout    <= 1'b0;

            if (rx_valid && state != RECV)
                overrun <= 1'b1;

            case (state)
                RECV: begin
                    if (expire)
                        timeout <= 1'b1;
                    if (rx_valid) begin
                        to_cnt <= '0;
                        if (expire) begin
                            // Byte arriving on the expiry cycle opens a new frame.
                            rx_buf[63:56] <= rx_data;
                            idx           <= 3'd1;
                        end else if (idx == 3'd7) begin
                            mode_q      <= mode;
                            rx_buf[7:0] <= rx_data;
                            if (mode)
                                enc_in <= {rx_buf[63:8], rx_data};
                            else
                                dec_in <= {rx_buf[63:8], rx_data};
                            idx        <= 3'd0;
                            settle_cnt <= 8'd0;
                            busy       <= 1'b1;
                            state      <= SETTLE;
                        end else begin
                            rx_buf[{~idx, 3'b111} -: 8] <= rx_data;
                            idx <= idx + 3'd1;
                        end
                    end else if (expire) begin
                        idx    <= 3'd0;
                        to_cnt <= '0;
                    end else if (idx != 3'd0 && TIMEOUT_CYCLES != 0) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                        out_buf <= mode_q ? enc_out : dec_out;
                        state   <= SEND;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end

                SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= out_buf[{~idx, 3'b111} -: 8];
                        tx_start <= 1'b1;
                        state    <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (tx_busy)
                        state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (idx == 3'd7) begin
                            idx        <= 3'd0;
                            block_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            busy       <= 1'b0;
                            state      <= RECV;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SEND;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= RECV;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
